// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, limits and range helper for the data-memory responder
package dmem_pkg;
  localparam int DMEM_MAX_LATENCY = 15;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;
  function automatic logic addr_oob(input logic [31:0] addr, input int lo);
    return |(addr >> lo);
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port read-first 32-bit RAM with one-cycle registered read
//   CLK   : clock
//   we    : write enable for addr
//   addr  : word index
//   wdata : store data
//   rdata : contents of addr before this edge's write
module dmem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge CLK) begin
    rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: accepts one load/store at a time and answers after LATENCY cycles
//   CLK, reset     : clock, synchronous active-high reset
//   i_req_*        : request (valid, read, write, addr, wdata); o_req_ready backpressure
//   o_resp_valid   : one-cycle completion strobe
//   o_resp_rdata   : load data, held until the next response
//   o_resp_err     : address out of range, held until the next response
//   o_busy         : an operation is in flight
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3,
  parameter int BYTE_ADDR  = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_read,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_busy
);
  localparam int LAT = LATENCY < 1 ? 1 : (LATENCY > DMEM_MAX_LATENCY ? DMEM_MAX_LATENCY : LATENCY);
  localparam logic [3:0] CNT_INIT = 4'(LAT > 1 ? LAT - 2 : 0);
  dmem_req_t             w_req;
  dmem_state_t           r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] w_idx, r_idx, w_ram_addr;
  logic [31:0]           r_wdata, w_ram_wdata, w_ram_rdata, w_rd, r_rd_hold;
  logic                  r_we, r_err, r_err_hold, w_oob, w_acc, w_ram_we, w_unused;
  assign w_req = '{read: i_req_read, write: i_req_write, addr: i_req_addr, wdata: i_req_wdata};
  assign w_idx = BYTE_ADDR != 0 ? w_req.addr[ADDR_WIDTH+1:2] : w_req.addr[ADDR_WIDTH-1:0];
  assign w_oob = addr_oob(w_req.addr, BYTE_ADDR != 0 ? ADDR_WIDTH + 2 : ADDR_WIDTH);
  assign w_unused = ^w_req.addr[1:0];
  assign o_req_ready = r_state != WAIT;
  assign o_busy = r_state != IDLE;
  assign o_resp_valid = r_state == RESP;
  assign w_acc = i_req_valid & o_req_ready & (w_req.read | w_req.write);
  // The RAM is touched on the edge right before RESP so its registered read is
  // still the pre-write value during RESP; it re-reads every edge, so an earlier
  // access would let a read-and-write return its own new data.
  assign w_ram_we = LAT == 1 ? w_acc & w_req.write & ~w_oob : r_state == WAIT && r_cnt == 4'd0 && r_we;
  assign w_ram_addr = LAT == 1 ? w_idx : r_idx;
  assign w_ram_wdata = LAT == 1 ? w_req.wdata : r_wdata;
  assign w_rd = r_err ? 32'd0 : w_ram_rdata;
  assign o_resp_rdata = r_state == RESP ? w_rd : r_rd_hold;
  assign o_resp_err = r_state == RESP ? r_err : r_err_hold;
  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .CLK  (CLK),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .wdata(w_ram_wdata),
    .rdata(w_ram_rdata)
  );
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
      r_rd_hold <= 32'd0;
      r_err_hold <= 1'b0;
    end else begin
      if (r_state == RESP) begin
        r_rd_hold <= w_rd;
        r_err_hold <= r_err;
      end
      if (w_acc) begin
        r_state <= LAT == 1 ? RESP : WAIT;
        r_cnt <= CNT_INIT;
      end else if (r_state == RESP) begin
        r_state <= IDLE;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd0) r_state <= RESP;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (w_acc) begin
      r_idx <= w_idx;
      r_wdata <= w_req.wdata;
      r_we <= w_req.write & ~w_oob;
      r_err <= w_oob;
    end
  end
endmodule
